// File: rtl/draw_pkg.sv
// Shared widths, screen/tile geometry, FSM encoding and rectangle payload
// for the draw scheduler.
package draw_pkg;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned DIM_W    = 5;
  localparam int unsigned COL_W    = 3;
  localparam int unsigned ID_W     = 3;
  localparam int unsigned TIDX_W   = 3;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;
  localparam int unsigned TILE     = 20;
  localparam int unsigned TILES_X  = SCREEN_W / TILE;
  localparam int unsigned TILES_Y  = SCREEN_H / TILE;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_ARB         = 3'd1,
    ST_DRAW        = 3'd2,
    ST_RELEASE     = 3'd3,
    ST_CLEAR_SETUP = 3'd4
  } state_e;

  typedef struct packed {
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [DIM_W-1:0] w;
    logic [DIM_W-1:0] h;
    logic [COL_W-1:0] c;
  } rect_t;

  // Background tile at (col,row); largest origin is (140,100), so no overflow.
  function automatic rect_t tile_rect(input logic [TIDX_W-1:0] col,
                                      input logic [TIDX_W-1:0] row,
                                      input logic [COL_W-1:0]  colour);
    rect_t r;
    r.x = X_W'(32'(col) * TILE);
    r.y = Y_W'(32'(row) * TILE);
    r.w = DIM_W'(TILE);
    r.h = DIM_W'(TILE);
    r.c = colour;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after i_ptr, wrapping.
module rr_arbiter
  import draw_pkg::*;
#(
  parameter int unsigned N_REQ = 4
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic [ID_W-1:0]  o_grant,
  output logic             o_valid
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [ID_W-1:0]    w_off;
  logic [ID_W:0]      w_sum;

  // Rotate requests so i_ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    w_dbl = {i_req, i_req};
    w_rot = N_REQ'(w_dbl >> i_ptr);
    w_off = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = ID_W'(k);
    end
    w_sum = (ID_W+1)'(i_ptr) + (ID_W+1)'(w_off);
    if (w_sum >= (ID_W+1)'(N_REQ)) w_sum = w_sum - (ID_W+1)'(N_REQ);
    o_grant = ID_W'(w_sum);
    o_valid = |i_req;
  end

endmodule

// File: rtl/draw_scheduler.sv
// Round-robin scheduler sharing one rectangle drawer between N_REQ requesters.
// Define DRAW_SCHEDULER_CLEAR_EN to enable the per-frame background clear pass
// (48 tiles of 20x20 in BG_COLOUR, started by frame_start).
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned      N_REQ     = 4,
  parameter logic [COL_W-1:0] BG_COLOUR = 3'b000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*X_W-1:0]     req_x,
  input  logic [N_REQ*Y_W-1:0]     req_y,
  input  logic [N_REQ*DIM_W-1:0]   req_w,
  input  logic [N_REQ*DIM_W-1:0]   req_h,
  input  logic [N_REQ*COL_W-1:0]   req_c,
  output logic [N_REQ-1:0]         ack,
  output logic [X_W-1:0]           drw_x,
  output logic [Y_W-1:0]           drw_y,
  output logic [DIM_W-1:0]         drw_w,
  output logic [DIM_W-1:0]         drw_h,
  output logic [COL_W-1:0]         drw_c,
  output logic                     drw_load,
  output logic                     drw_enable,
  input  logic                     drw_done,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id,
  output logic                     clear_active
);

  state_e           r_state, w_state_nxt;
  logic [ID_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic [ID_W-1:0]  r_grant_id, w_grant_id_nxt;
  logic [N_REQ-1:0] r_ack, w_ack_nxt;
  rect_t            r_rect, w_rect_nxt, w_sel_rect;
  logic             r_drw_on, w_drw_on_nxt;
  logic             r_busy;
  logic [ID_W-1:0]  w_arb_grant;
  logic             w_arb_valid;
  logic             w_in_clear;

`ifdef DRAW_SCHEDULER_CLEAR_EN
  logic              r_clear_pending, w_clear_pending_nxt;
  logic              r_clear_active, w_clear_active_nxt;
  logic [TIDX_W-1:0] r_col, w_col_nxt;
  logic [TIDX_W-1:0] r_row, w_row_nxt;
  assign w_in_clear = r_clear_active;
`else
  logic w_unused;
  assign w_unused   = ^{frame_start, BG_COLOUR};
  assign w_in_clear = 1'b0;
`endif

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .i_req   (req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_arb_grant),
    .o_valid (w_arb_valid)
  );

  // Select the packed rectangle fields of the arbitration winner.
  always_comb begin
    w_sel_rect = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (w_arb_grant == ID_W'(i)) begin
        w_sel_rect.x = req_x[i*X_W   +: X_W];
        w_sel_rect.y = req_y[i*Y_W   +: Y_W];
        w_sel_rect.w = req_w[i*DIM_W +: DIM_W];
        w_sel_rect.h = req_h[i*DIM_W +: DIM_W];
        w_sel_rect.c = req_c[i*COL_W +: COL_W];
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_grant_id_nxt = r_grant_id;
    w_ack_nxt      = '0;
    w_rect_nxt     = r_rect;
    w_drw_on_nxt   = 1'b0;
`ifdef DRAW_SCHEDULER_CLEAR_EN
    w_clear_pending_nxt = r_clear_pending | frame_start;
    w_clear_active_nxt  = r_clear_active;
    w_col_nxt           = r_col;
    w_row_nxt           = r_row;
`endif
    case (r_state)
      ST_IDLE: begin
`ifdef DRAW_SCHEDULER_CLEAR_EN
        if (r_clear_pending) begin
          w_state_nxt         = ST_CLEAR_SETUP;
          w_clear_pending_nxt = frame_start;
          w_clear_active_nxt  = 1'b1;
          w_col_nxt           = '0;
          w_row_nxt           = '0;
        end else
`endif
        if (|req) w_state_nxt = ST_ARB;
      end
      ST_ARB: begin
        if (!w_arb_valid) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_grant_id_nxt = w_arb_grant;
          w_rect_nxt     = w_sel_rect;
          if (w_sel_rect.w == '0 || w_sel_rect.h == '0) begin
            // Degenerate rectangle: nothing to draw, but the requester is still served.
            w_state_nxt = ST_RELEASE;
            w_ack_nxt   = N_REQ'(1) << w_arb_grant;
          end else begin
            w_state_nxt  = ST_DRAW;
            w_drw_on_nxt = 1'b1;
          end
        end
      end
      ST_DRAW: begin
        w_drw_on_nxt = 1'b1;
        if (drw_done) begin
          w_drw_on_nxt = 1'b0;
          w_state_nxt  = ST_RELEASE;
          if (!w_in_clear) w_ack_nxt = N_REQ'(1) << r_grant_id;
        end
      end
      ST_RELEASE: begin
`ifdef DRAW_SCHEDULER_CLEAR_EN
        if (r_clear_active) begin
          w_state_nxt = ST_CLEAR_SETUP;
          if (r_col == TIDX_W'(TILES_X - 1)) begin
            w_col_nxt = '0;
            if (r_row == TIDX_W'(TILES_Y - 1)) begin
              w_state_nxt        = ST_IDLE;
              w_clear_active_nxt = 1'b0;
            end else begin
              w_row_nxt = TIDX_W'(r_row + TIDX_W'(1));
            end
          end else begin
            w_col_nxt = TIDX_W'(r_col + TIDX_W'(1));
          end
        end else
`endif
        begin
          w_state_nxt  = ST_IDLE;
          w_rr_ptr_nxt = (r_grant_id == ID_W'(N_REQ - 1)) ? '0
                                                           : ID_W'(r_grant_id + ID_W'(1));
        end
      end
`ifdef DRAW_SCHEDULER_CLEAR_EN
      ST_CLEAR_SETUP: begin
        w_rect_nxt   = tile_rect(r_col, r_row, BG_COLOUR);
        w_state_nxt  = ST_DRAW;
        w_drw_on_nxt = 1'b1;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Registered outputs and bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_ack      <= '0;
      r_rect     <= '0;
      r_drw_on   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_ack      <= w_ack_nxt;
      r_rect     <= w_rect_nxt;
      r_drw_on   <= w_drw_on_nxt;
      r_busy     <= (w_state_nxt != ST_IDLE);
    end
  end

`ifdef DRAW_SCHEDULER_CLEAR_EN
  // Clear-pass request flag and tile position.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_clear_pending <= 1'b0;
      r_clear_active  <= 1'b0;
      r_col           <= '0;
      r_row           <= '0;
    end else begin
      r_clear_pending <= w_clear_pending_nxt;
      r_clear_active  <= w_clear_active_nxt;
      r_col           <= w_col_nxt;
      r_row           <= w_row_nxt;
    end
  end
  assign clear_active = r_clear_active;
`else
  assign clear_active = 1'b0;
`endif

  assign ack        = r_ack;
  assign drw_x      = r_rect.x;
  assign drw_y      = r_rect.y;
  assign drw_w      = r_rect.w;
  assign drw_h      = r_rect.h;
  assign drw_c      = r_rect.c;
  assign drw_load   = r_drw_on;
  assign drw_enable = r_drw_on;
  assign busy       = r_busy;
  assign grant_id   = r_grant_id;

endmodule

// File: tb/tb_draw_scheduler.sv
// Scoreboard bench for draw_scheduler: stimulus pushes expected draws/acks,
// a monitor pops and compares whenever the drawer is started or an ack fires.
module tb_draw_scheduler;
  import draw_pkg::*;

  localparam int unsigned      N  = 4;
  localparam logic [COL_W-1:0] BG = 3'b010;

  typedef struct packed { rect_t rect; logic clr; } exp_draw_t;
  typedef struct { string name; logic [63:0] act; logic [63:0] exp; } chk_t;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               frame_start = 1'b0;
  logic [N-1:0]       req = '0;
  logic [N*X_W-1:0]   req_x = '0;
  logic [N*Y_W-1:0]   req_y = '0;
  logic [N*DIM_W-1:0] req_w = '0;
  logic [N*DIM_W-1:0] req_h = '0;
  logic [N*COL_W-1:0] req_c = '0;
  logic [N-1:0]       ack;
  logic [X_W-1:0]     drw_x;
  logic [Y_W-1:0]     drw_y;
  logic [DIM_W-1:0]   drw_w;
  logic [DIM_W-1:0]   drw_h;
  logic [COL_W-1:0]   drw_c;
  logic               drw_load, drw_enable;
  logic               drw_done = 1'b0;
  logic               busy;
  logic [ID_W-1:0]    grant_id;
  logic               clear_active;

  exp_draw_t exp_draw_q[$];
  int        exp_ack_q[$];
  chk_t      chk_q[$];
  int        n_cmp = 0;
  int        n_fail = 0;
  logic      prev_en = 1'b0;
  rect_t     slot_rect [N];
  int        model_ptr = 0;
  int        dcnt = 0;
  rect_t     mon_rect;

  assign mon_rect = {drw_x, drw_y, drw_w, drw_h, drw_c};

  draw_scheduler #(.N_REQ(N), .BG_COLOUR(BG)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .req(req), .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h), .req_c(req_c),
    .ack(ack), .drw_x(drw_x), .drw_y(drw_y), .drw_w(drw_w), .drw_h(drw_h), .drw_c(drw_c),
    .drw_load(drw_load), .drw_enable(drw_enable), .drw_done(drw_done),
    .busy(busy), .grant_id(grant_id), .clear_active(clear_active)
  );

  always #5 clk = ~clk;

  // Drawer model: done w*h+2 cycles after enable rises, cleared when enable drops.
  always @(posedge clk) begin
    if (!drw_enable) begin
      dcnt     <= 0;
      drw_done <= 1'b0;
    end else begin
      dcnt <= dcnt + 1;
      if (dcnt + 1 >= int'(drw_w) * int'(drw_h) + 2) drw_done <= 1'b1;
    end
  end

  // Monitor: compare drawer starts, acks and queued directed checks.
  always @(posedge clk) begin
    exp_draw_t e;
    chk_t      c;
    int        id;
    #1;
    if (drw_enable && !prev_en) begin
      n_cmp++;
      if (exp_draw_q.size() == 0) begin
        n_fail++;
        $display("FAIL draw_unexpected: got rect %h clr %b, none required", mon_rect, clear_active);
      end else begin
        e = exp_draw_q.pop_front();
        if ({mon_rect, clear_active} !== e) begin
          n_fail++;
          $display("FAIL draw_rect: got %h clr %b, required %h clr %b",
                   mon_rect, clear_active, e.rect, e.clr);
        end
      end
    end
    if (ack != '0) begin
      n_cmp++;
      if (exp_ack_q.size() == 0) begin
        n_fail++;
        $display("FAIL ack_unexpected: got %b, none required", ack);
      end else begin
        id = exp_ack_q.pop_front();
        if (ack !== (N'(1) << id)) begin
          n_fail++;
          $display("FAIL ack_order: got %b, required %b", ack, N'(1) << id);
        end
      end
    end
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      n_cmp++;
      if (c.act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %0h, required %0h", c.name, c.act, c.exp);
      end
    end
    prev_en = drw_enable;
  end

  task automatic push_chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.act  = act;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  // One cycle; requesters drop their request as soon as they see ack.
  task automatic tick();
    @(posedge clk);
    #1;
    req = req & ~ack;
  endtask

  task automatic set_slot(input int i, input rect_t r);
    slot_rect[i] = r;
    req_x[i*X_W   +: X_W]   = r.x;
    req_y[i*Y_W   +: Y_W]   = r.y;
    req_w[i*DIM_W +: DIM_W] = r.w;
    req_h[i*DIM_W +: DIM_W] = r.h;
    req_c[i*COL_W +: COL_W] = r.c;
  endtask

  function automatic rect_t mk_rect(input int x, input int y, input int w, input int h, input int c);
    rect_t r;
    r.x = X_W'(x);
    r.y = Y_W'(y);
    r.w = DIM_W'(w);
    r.h = DIM_W'(h);
    r.c = COL_W'(c);
    return r;
  endfunction

  function automatic rect_t rand_rect();
    return mk_rect(int'($urandom_range(0, 159)), int'($urandom_range(0, 119)),
                   int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), int'($urandom_range(0, 7)));
  endfunction

  // Reference: requests raised together are served round-robin from the pointer.
  task automatic model_batch(input logic [N-1:0] mask);
    logic [N-1:0] pend;
    int g;
    pend = mask;
    while (pend != '0) begin
      g = model_ptr;
      while (!pend[g]) g = (g + 1) % int'(N);
      pend[g] = 1'b0;
      if (slot_rect[g].w != '0 && slot_rect[g].h != '0)
        exp_draw_q.push_back('{rect: slot_rect[g], clr: 1'b0});
      exp_ack_q.push_back(g);
      model_ptr = (g + 1) % int'(N);
    end
  endtask

  task automatic model_clear_pass();
    for (int row = 0; row < 6; row++)
      for (int col = 0; col < 8; col++)
        exp_draw_q.push_back('{rect: mk_rect(col * 20, row * 20, 20, 20, int'(BG)), clr: 1'b1});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_draw_q.size() != 0 || exp_ack_q.size() != 0 || req != '0 || busy) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) push_chk({name, "_timeout"}, 64'd0, 64'd1);
    repeat (2) tick();
  endtask

  task automatic wait_enable(input string name);
    int n;
    n = 0;
    while (!drw_enable && n < 200) begin
      tick();
      n++;
    end
    if (!drw_enable) push_chk({name, "_no_enable"}, 64'd0, 64'd1);
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    int n;
    logic [N-1:0] mask;

    repeat (3) @(posedge clk);
    #1;
    push_chk("reset_ctrl", 64'({ack, drw_load, drw_enable, busy, grant_id, clear_active}), 64'd0);
    push_chk("reset_rect", 64'(mon_rect), 64'd0);
    reset = 1'b0;
    tick();

    // Single request: latency to enable and done-to-ack.
    set_slot(0, mk_rect(10, 5, 3, 2, 4));
    model_batch(4'b0001);
    req = 4'b0001;
    tick();
    push_chk("lat_cycle1_enable", 64'(drw_enable), 64'd0);
    push_chk("busy_in_arb", 64'(busy), 64'd1);
    tick();
    push_chk("lat_cycle2_enable", 64'(drw_enable), 64'd1);
    push_chk("load_with_enable", 64'(drw_load), 64'd1);
    push_chk("grant_id_0", 64'(grant_id), 64'd0);
    n = 0;
    while (!drw_done && n < 100) begin
      tick();
      n++;
    end
    if (!drw_done) push_chk("done_timeout", 64'd0, 64'd1);
    tick();
    push_chk("done_to_ack", 64'(ack), 64'b0001);
    push_chk("enable_drop_at_ack", 64'(drw_enable), 64'd0);
    tick();
    push_chk("busy_idle_after_ack", 64'(busy), 64'd0);
    wait_drain("single", 50);

    // Zero width: acked through ARB->RELEASE with no drawer activity.
    set_slot(1, mk_rect(40, 20, 0, 3, 2));
    model_batch(4'b0010);
    req = 4'b0010;
    tick();
    tick();
    push_chk("zero_size_ack", 64'(ack), 64'b0010);
    wait_drain("zero_size", 50);

    // Request withdrawn mid-draw still completes and is acked.
    set_slot(2, mk_rect(20, 30, 4, 3, 1));
    model_batch(4'b0100);
    req = 4'b0100;
    wait_enable("drop_mid");
    tick();
    tick();
    req[2] = 1'b0;
    wait_drain("drop_mid", 100);

    // Reset mid-draw: outputs cleared, no ack, pointer back to 0.
    set_slot(3, mk_rect(50, 60, 5, 5, 7));
    exp_draw_q.push_back('{rect: slot_rect[3], clr: 1'b0});
    req = 4'b1000;
    wait_enable("reset_mid");
    repeat (3) tick();
    reset = 1'b1;
    tick();
    push_chk("reset_mid_ctrl", 64'({ack, drw_load, drw_enable, busy, grant_id, clear_active}), 64'd0);
    push_chk("reset_mid_rect", 64'(mon_rect), 64'd0);
    reset = 1'b0;
    req = '0;
    model_ptr = 0;
    repeat (40) tick();

    // Full contention, then a partial re-raise.
    for (int i = 0; i < int'(N); i++) set_slot(i, mk_rect(i * 30, i * 20, 2 + i, 3, i + 1));
    model_batch(4'b1111);
    req = 4'b1111;
    wait_drain("contention", 400);
    set_slot(0, mk_rect(7, 9, 3, 3, 6));
    set_slot(2, mk_rect(99, 88, 2, 5, 3));
    model_batch(4'b0101);
    req = 4'b0101;
    wait_drain("rereq", 200);

    // Randomized batches.
    repeat (20) begin
      mask = N'($urandom_range(1, 15));
      for (int i = 0; i < int'(N); i++) set_slot(i, rand_rect());
      model_batch(mask);
      req = mask;
      wait_drain("random", 600);
    end

`ifdef DRAW_SCHEDULER_CLEAR_EN
    // frame_start during a draw: draw finishes, two passes run, then req3.
    set_slot(0, mk_rect(0, 0, 6, 6, 5));
    set_slot(3, mk_rect(30, 40, 2, 2, 6));
    model_batch(4'b0001);
    model_clear_pass();
    model_clear_pass();
    model_batch(4'b1000);
    req = 4'b0001;
    wait_enable("clear_pre");
    tick();
    req[3] = 1'b1;
    pulse_frame();
    n = 0;
    while (!clear_active && n < 200) begin
      tick();
      n++;
    end
    push_chk("clear_started", 64'(clear_active), 64'd1);
    repeat (30) tick();
    pulse_frame();
    repeat (500) tick();
    pulse_frame();
    wait_drain("clear", 60000);
    push_chk("clear_active_end", 64'(clear_active), 64'd0);
`else
    // Without the clear feature frame_start does nothing.
    pulse_frame();
    repeat (5) tick();
    pulse_frame();
    for (int i = 0; i < 3; i++) begin
      repeat (10) tick();
      push_chk("no_clear_active", 64'(clear_active), 64'd0);
      push_chk("no_clear_busy", 64'(busy), 64'd0);
    end
`endif

    repeat (5) tick();
    if (exp_draw_q.size() != 0 || exp_ack_q.size() != 0)
      push_chk("leftover_expectations", 64'(exp_draw_q.size() + exp_ack_q.size()), 64'd0);
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
